// File: rtl/mtimer_mmio.sv
// mtimer_mmio: memory-mapped RISC-V machine timer (mtime / mtimecmp).
//
// Sits behind the MMU's timer-window decode on the data-memory side. A
// prescaler produces an increment tick every PRESCALE clocks; mtime is a
// 64-bit free-running counter and irq_mtimecmp_o is the registered result of
// the unsigned compare mtime >= mtimecmp.
//
// Access protocol: there is no valid/ready pair. An access happens on any
// rising clk edge where sel_i & |be_i; it is accepted in zero cycles and can
// never be stalled. we_i picks write versus read. Read data appears on do_o
// in the cycle after the request and then holds until the next read.
//
// Register map (addr_i[3:2]): 0 mtime[31:0], 1 mtime[63:32],
//                             2 mtimecmp[31:0], 3 mtimecmp[63:32].
//
// Ports:
//   clk             in   1   clock
//   resetb          in   1   synchronous reset, active-low
//   sel_i           in   1   access targets the timer window this cycle
//   we_i            in   1   1 = write, 0 = read (qualified by sel_i)
//   be_i            in   4   byte enables; no access when all zero
//   addr_i          in   4   byte offset; [3:2] selects register
//   di_i            in   32  write data
//   do_o            out  32  registered read data
//   irq_mtimecmp_o  out  1   registered level interrupt request
module mtimer_mmio #(
  parameter int PRESCALE = 1,
  parameter int PS_W     = 16
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        sel_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [3:0]  addr_i,
  input  logic [31:0] di_i,
  output logic [31:0] do_o,
  output logic        irq_mtimecmp_o
);

  localparam logic [PS_W-1:0] PS_RELOAD = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] ps_q, ps_d;
  logic [63:0]     mtime_q, mtime_d;
  logic [63:0]     mtimecmp_q, mtimecmp_d;
  logic [31:0]     do_q, do_d;
  logic            irq_q, irq_d;

  logic            tick;
  logic            wr_en;
  logic            rd_en;
  logic [63:0]     mtime_inc;
  logic [31:0]     rd_mux;
  logic            addr_unused;

  // Byte offset within a word carries no meaning here; the MMU does lane work.
  assign addr_unused = ^addr_i[1:0];

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

  assign wr_en = sel_i &  we_i & (|be_i);
  assign rd_en = sel_i & ~we_i & (|be_i);
  assign tick  = (ps_q == '0);

  always_comb begin
    ps_d       = tick ? PS_RELOAD : (ps_q - PS_W'(1));
    mtime_inc  = mtime_q + 64'd1;
    mtime_d    = tick ? mtime_inc : mtime_q;
    mtimecmp_d = mtimecmp_q;

    // Writes merge over the already-incremented value. For a lo write the hi
    // half is therefore carried only from the OLD lo, never from written data;
    // for a hi write the unwritten hi bytes come from the incremented hi.
    if (wr_en) begin
      unique case (addr_i[3:2])
        2'd0: mtime_d[31:0]     = byte_merge(mtime_d[31:0],     di_i, be_i);
        2'd1: mtime_d[63:32]    = byte_merge(mtime_d[63:32],    di_i, be_i);
        2'd2: mtimecmp_d[31:0]  = byte_merge(mtimecmp_q[31:0],  di_i, be_i);
        2'd3: mtimecmp_d[63:32] = byte_merge(mtimecmp_q[63:32], di_i, be_i);
        default: ;
      endcase
    end

    // Reads return the value held before this edge's updates.
    unique case (addr_i[3:2])
      2'd0:    rd_mux = mtime_q[31:0];
      2'd1:    rd_mux = mtime_q[63:32];
      2'd2:    rd_mux = mtimecmp_q[31:0];
      default: rd_mux = mtimecmp_q[63:32];
    endcase
    do_d  = rd_en ? rd_mux : do_q;

    irq_d = (mtime_q >= mtimecmp_q);
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      ps_q       <= PS_RELOAD;
      mtime_q    <= 64'd0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      do_q       <= 32'd0;
      irq_q      <= 1'b0;
    end else begin
      ps_q       <= ps_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      do_q       <= do_d;
      irq_q      <= irq_d;
    end
  end

  assign do_o           = do_q;
  assign irq_mtimecmp_o = irq_q;

endmodule

// File: tb/tb_mtimer_mmio.sv
// tb_mtimer_mmio: bench for mtimer_mmio. Two instances share one stimulus
// stream: p1 (PRESCALE=1) and p4 (PRESCALE=4). A behavioural model tracks the
// timer per instance from cycles-since-reset; a compare process checks do/irq
// of both instances every cycle, and directed reads pin literal values.
module tb_mtimer_mmio;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetb = 1'b0;
  logic        sel = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [3:0]  addr = 4'h0;
  logic [31:0] di = 32'h0;
  logic [31:0] do0, do1;
  logic        irq0, irq1;

  mtimer_mmio #(.PRESCALE(1), .PS_W(16)) dut0 (
    .clk(clk), .resetb(resetb), .sel_i(sel), .we_i(we), .be_i(be),
    .addr_i(addr), .di_i(di), .do_o(do0), .irq_mtimecmp_o(irq0)
  );

  mtimer_mmio #(.PRESCALE(4), .PS_W(16)) dut1 (
    .clk(clk), .resetb(resetb), .sel_i(sel), .we_i(we), .be_i(be),
    .addr_i(addr), .di_i(di), .do_o(do1), .irq_mtimecmp_o(irq1)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int unsigned     presc [2] = '{1, 4};
  logic [63:0]     m_time[2];
  logic [63:0]     m_cmp [2];
  logic [31:0]     m_do  [2];
  logic            m_irq [2];
  longint unsigned m_cyc [2];

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] b);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = b[i] ? n[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  function automatic logic [63:0] next_time(input logic [63:0] t, input bit tk,
                                            input bit w, input logic [1:0] r,
                                            input logic [31:0] d, input logic [3:0] b);
    logic [63:0] n;
    n = tk ? t + 64'd1 : t;
    if (w && r == 2'd0) n[31:0]  = merge(n[31:0],  d, b);
    if (w && r == 2'd1) n[63:32] = merge(n[63:32], d, b);
    return n;
  endfunction

  function automatic logic [63:0] next_cmp(input logic [63:0] c, input bit w,
                                           input logic [1:0] r, input logic [31:0] d,
                                           input logic [3:0] b);
    logic [63:0] n;
    n = c;
    if (w && r == 2'd2) n[31:0]  = merge(c[31:0],  d, b);
    if (w && r == 2'd3) n[63:32] = merge(c[63:32], d, b);
    return n;
  endfunction

  function automatic logic [31:0] reg_val(input logic [63:0] t, input logic [63:0] c,
                                          input logic [1:0] r);
    case (r)
      2'd0:    return t[31:0];
      2'd1:    return t[63:32];
      2'd2:    return c[31:0];
      default: return c[63:32];
    endcase
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!resetb) begin
        m_time[k] <= 64'd0;
        m_cmp[k]  <= '1;
        m_cyc[k]  <= 0;
        m_do[k]   <= 32'd0;
        m_irq[k]  <= 1'b0;
      end else begin
        // First tick lands PRESCALE cycles after reset, then every PRESCALE.
        m_cyc[k]  <= m_cyc[k] + 1;
        m_time[k] <= next_time(m_time[k], (m_cyc[k] % presc[k]) == presc[k] - 1,
                               sel && we && (be != 0), addr[3:2], di, be);
        m_cmp[k]  <= next_cmp(m_cmp[k], sel && we && (be != 0), addr[3:2], di, be);
        if (sel && !we && (be != 0)) m_do[k] <= reg_val(m_time[k], m_cmp[k], addr[3:2]);
        m_irq[k]  <= (m_time[k] >= m_cmp[k]);
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    check("do_p1",  do0,  m_do[0]);
    check("irq_p1", irq0, m_irq[0]);
    check("do_p4",  do1,  m_do[1]);
    check("irq_p4", irq1, m_irq[1]);
  end

  // ---------------- driver tasks ----------------
  // Each task starts just after a falling edge and ends on a falling edge.
  task automatic drive_idle();
    sel = 1'b0; we = 1'b0; be = 4'h0; addr = 4'h0; di = 32'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    #2;
    resetb = 1'b0;
    sel = 1'b1; we = 1'b0; be = 4'hF; addr = 4'h0;  // read that must be discarded
    repeat (n) @(posedge clk);
    #1 drive_idle();
    @(negedge clk);
    #1 resetb = 1'b1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
    #2;
    sel = 1'b1; we = 1'b1; addr = a; di = d; be = b;
    @(posedge clk);
    #1 drive_idle();
    @(negedge clk);
  endtask

  task automatic rd(input logic [3:0] a, input logic [3:0] b,
                    output logic [31:0] r0, output logic [31:0] r1);
    #2;
    sel = 1'b1; we = 1'b0; addr = a; be = b;
    @(posedge clk);
    #1;
    r0 = do0;
    r1 = do1;
    drive_idle();
    @(negedge clk);
  endtask

  task automatic rd_chk(input string name, input logic [3:0] a,
                        input logic [31:0] e0, input logic [31:0] e1, input bit both);
    logic [31:0] r0, r1;
    rd(a, 4'hF, r0, r1);
    exp_q.push_back(e0);
    check({name, "_p1"}, r0, exp_q.pop_front());
    if (both) begin
      exp_q.push_back(e1);
      check({name, "_p4"}, r1, exp_q.pop_front());
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed tests ----------------
  initial begin
    logic [31:0] r0, r1;

    // T1 reset values
    do_reset(2);
    check("rst_do_p1",  do0,  32'h0);
    check("rst_irq_p1", irq0, 1'b0);
    check("rst_do_p4",  do1,  32'h0);
    check("rst_irq_p4", irq1, 1'b0);
    rd_chk("rst_lo",    4'd0,  32'h0,         32'h0,         1'b1);
    rd_chk("rst_cmplo", 4'd8,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    rd_chk("rst_cmphi", 4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);

    // T2 prescale: eight edges after release, then read pre-edge value
    do_reset(1);
    idle(8);
    rd_chk("presc", 4'd0, 32'd8, 32'd2, 1'b1);

    // T3 carry lo->hi
    do_reset(1);
    wr(4'd4, 32'h0, 4'hF);
    wr(4'd0, 32'hFFFF_FFFE, 4'hF);
    idle(2);
    rd_chk("carry_lo", 4'd0, 32'h0, 32'h0, 1'b0);
    rd_chk("carry_hi", 4'd4, 32'h1, 32'h0, 1'b0);
    // written all-ones lo on a tick edge: no carry from the written value
    wr(4'd4, 32'h5, 4'hF);
    wr(4'd0, 32'hFFFF_FFFF, 4'hF);
    rd_chk("wcoll_hi",  4'd4, 32'h5, 32'h0, 1'b0);
    rd_chk("wcoll_lo",  4'd0, 32'h0, 32'h0, 1'b0);
    rd_chk("wcoll_hi2", 4'd4, 32'h6, 32'h0, 1'b0);
    // partial lo write on a tick: unwritten bytes take incremented lo
    wr(4'd0, 32'h10, 4'hF);
    wr(4'd0, 32'hAA00_0000, 4'b1000);
    rd_chk("plo", 4'd0, 32'hAA00_0011, 32'h0, 1'b0);
    // partial hi write on a carrying tick: unwritten hi bytes take hi+1
    wr(4'd0, 32'hFFFF_FFFF, 4'hF);
    wr(4'd4, 32'hDD00_0000, 4'b1000);
    rd_chk("phi", 4'd4, 32'hDD00_0007, 32'h0, 1'b0);

    // T4 compare
    do_reset(1);
    wr(4'd12, 32'h0, 4'hF);
    wr(4'd8,  32'd10, 4'hF);
    idle(8);
    check("irq_pre",  irq0, 1'b0);
    idle(1);
    check("irq_rise", irq0, 1'b1);
    wr(4'd8, 32'd100, 4'hF);
    check("irq_hold", irq0, 1'b1);
    idle(1);
    check("irq_fall", irq0, 1'b0);

    // T5 byte enables
    do_reset(1);
    wr(4'd8, 32'h0000_AB00, 4'b0010);
    rd_chk("be_one", 4'd8, 32'hFFFF_ABFF, 32'hFFFF_ABFF, 1'b1);
    wr(4'd8, 32'h0, 4'b0000);
    rd_chk("be_zero", 4'd8, 32'hFFFF_ABFF, 32'hFFFF_ABFF, 1'b1);
    rd(4'd0, 4'b0000, r0, r1);
    check("be0rd_p1", r0, 32'hFFFF_ABFF);
    check("be0rd_p4", r1, 32'hFFFF_ABFF);
    // 64-bit wrap
    wr(4'd4, 32'hFFFF_FFFF, 4'hF);
    wr(4'd0, 32'hFFFF_FFFF, 4'hF);
    rd_chk("wrap_hi",  4'd4, 32'hFFFF_FFFF, 32'h0, 1'b0);
    rd_chk("wrap_lo",  4'd0, 32'h0,         32'h0, 1'b0);
    rd_chk("wrap_hi0", 4'd4, 32'h0,         32'h0, 1'b0);

    // T6 reset mid-run
    do_reset(1);
    wr(4'd4,  32'h0,    4'hF);
    wr(4'd0,  32'h1234, 4'hF);
    wr(4'd12, 32'h0,    4'hF);
    wr(4'd8,  32'h0,    4'hF);
    idle(1);
    check("mid_irq_p1", irq0, 1'b1);
    check("mid_irq_p4", irq1, 1'b1);
    do_reset(1);
    check("mid_do_p1",  do0,  32'h0);
    check("mid_irq0_p1", irq0, 1'b0);
    check("mid_do_p4",  do1,  32'h0);
    check("mid_irq0_p4", irq1, 1'b0);
    rd_chk("mid_t1", 4'd0, 32'd0, 32'd0, 1'b1);
    idle(2);
    rd_chk("mid_t4", 4'd0, 32'd3, 32'd0, 1'b1);
    rd_chk("mid_t5", 4'd0, 32'd4, 32'd1, 1'b1);
    rd_chk("mid_cmplo", 4'd8,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    rd_chk("mid_cmphi", 4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
